// File: rtl/line_clear_engine.sv
// Row-compaction engine: walks the playfield bottom-to-top, drops full rows by copying
// surviving rows down, then zero-fills the vacated top rows and reports the clear count.
module line_clear_engine #(
    parameter int width_p  = 16,
    parameter int height_p = 32
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic                        start_i,
    output logic                        ready_o,
    input  logic                        mem_ready_i,
    output logic [$clog2(height_p)-1:0] read_line_addr_o,
    input  logic [width_p-1:0]          read_line_data_i,
    output logic [$clog2(height_p)-1:0] write_addr_o,
    output logic [width_p-1:0]          write_data_o,
    output logic                        v_w_o,
    output logic                        done_o,
    output logic [$clog2(height_p):0]   lines_cleared_o
);

    localparam int AW = $clog2(height_p);
    localparam int PW = AW + 1;

    typedef logic [PW-1:0] ptr_t;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        FILL = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam ptr_t LAST_ROW = ptr_t'(height_p - 1);
    localparam ptr_t ONE      = ptr_t'(1);
    localparam ptr_t ZERO     = ptr_t'(0);

    state_e state_q, state_d;
    ptr_t   rd_ptr_q, rd_ptr_d;
    ptr_t   wr_ptr_q, wr_ptr_d;
    ptr_t   count_q, count_d;
    ptr_t   lines_q, lines_d;
    logic   v_w;
    logic [width_p-1:0] wdata;
    logic   row_full;

    assign row_full = &read_line_data_i;

    always_comb begin
        state_d  = state_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        lines_d  = lines_q;
        v_w      = 1'b0;
        wdata    = '0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d  = SCAN;
                    rd_ptr_d = LAST_ROW;
                    wr_ptr_d = LAST_ROW;
                    count_d  = ZERO;
                end
            end

            SCAN: begin
                if (mem_ready_i) begin
                    if (row_full) begin
                        count_d = count_q + ONE;
                    end else begin
                        // A row already sitting at its destination needs no rewrite.
                        if (rd_ptr_q != wr_ptr_q) begin
                            v_w   = 1'b1;
                            wdata = read_line_data_i;
                        end
                        wr_ptr_d = wr_ptr_q - ONE;
                    end
                    rd_ptr_d = rd_ptr_q - ONE;
                    if (rd_ptr_q == ZERO) begin
                        if (count_d != ZERO) begin
                            state_d = FILL;
                        end else begin
                            state_d = DONE;
                            lines_d = count_d;
                        end
                    end
                end
            end

            FILL: begin
                if (mem_ready_i) begin
                    v_w      = 1'b1;
                    wr_ptr_d = wr_ptr_q - ONE;
                    if (wr_ptr_q == ZERO) begin
                        state_d = DONE;
                        lines_d = count_q;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q  <= IDLE;
            rd_ptr_q <= ZERO;
            wr_ptr_q <= ZERO;
            count_q  <= ZERO;
            lines_q  <= ZERO;
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            lines_q  <= lines_d;
        end
    end

    assign ready_o          = (state_q == IDLE);
    assign done_o           = (state_q == DONE);
    assign v_w_o            = v_w;
    assign write_data_o     = wdata;
    assign read_line_addr_o = rd_ptr_q[AW-1:0];
    assign write_addr_o     = wr_ptr_q[AW-1:0];
    assign lines_cleared_o  = lines_q;

    // Memory safety invariants: never write into a stalled memory or above the read pointer.
    a_no_write_when_busy: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        v_w_o |-> mem_ready_i);
    a_write_below_read: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        (v_w_o && state_q == SCAN) |-> (wr_ptr_q > rd_ptr_q));

endmodule
